piso_tx: RTL
============

// Module: piso_tx
// PURPOSE
//   Framed parallel-in serial-out transmitter. Takes a WIDTH-bit word from the
//   4-bit PIPO register stage through a valid/ready handshake and sends it on a
//   single line as a frame: start bit, data MSB-first, optional parity, stop bit.
//   It is the stage directly downstream of the PIPO register and drives the
//   serial output pin.
// PARAMETERS
//   WIDTH         4   data word width, in bits (>=1)
//   CLKS_PER_BIT  2   clk cycles each serial bit is held (>=1)
// PORTS
//   clk       in   1      single clock; all logic on rising edge
//   rst       in   1      asynchronous, active-high reset
//   in_valid  in   1      p_in holds a word to send
//   in_ready  out  1      block can accept a word this cycle
//   p_in      in   WIDTH  parallel word, normally the PIPO p_out
//   s_out     out  1      serial line; idles high
//   busy      out  1      frame in progress
//   done      out  1      one-cycle pulse on the last cycle of the stop bit
// BEHAVIOUR
//   - Clocking and reset: one clock; reset is asynchronous and active-high.
//   - Reset values: s_out=1, in_ready=1, busy=0, done=0, state=IDLE, counters=0.
//   - Reset mid-frame: s_out goes to 1 at once (asynchronously), and the frame
//     is dropped. The block returns to IDLE and no done pulse is produced.
//   - Accept: a word is taken at any rising edge where in_valid && in_ready.
//     p_in is latched into the shift register at that edge. in_ready and busy
//     take their new values at that same edge. Changes on p_in after the accept
//     edge have no effect on the frame.
//   - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//       IDLE   s_out=1, in_ready=1, busy=0.
//       START  s_out=0 for CLKS_PER_BIT cycles.
//       DATA   sends WIDTH bits MSB-first; each bit is held CLKS_PER_BIT cycles.
//       PARITY s_out = even parity (XOR-reduce) of the latched word.
//       STOP   s_out=1 for CLKS_PER_BIT cycles; done=1 only in its final cycle.
//   - Latency: s_out drops to 0 in the first cycle after the accept edge.
//     Frame length is (WIDTH+2)*CLKS_PER_BIT cycles, plus CLKS_PER_BIT more when
//     the parity state is present.
//   - Back-to-back frames: in_ready returns to 1 in the cycle after done. There
//     is no idle gap beyond that one IDLE cycle.
//   - in_valid while busy is ignored; no word is latched.
//   - Counters: bit_cnt is $clog2(WIDTH+1) bits wide. The cycle counter is
//     $clog2(CLKS_PER_BIT+1) bits wide and wraps to 0 at CLKS_PER_BIT-1.
//     CLKS_PER_BIT=1 must work: every state lasts exactly one cycle.
// CONFIGURATION
//   PISO_TX_PARITY_EN defined:   PARITY state is built; frames carry an
//                                even-parity bit between DATA and STOP.
//   PISO_TX_PARITY_EN undefined: no PARITY state and no parity logic;
//                                DATA goes straight to STOP.
// STRUCTURE
//   - Package piso_pkg holds:
//       the state typedef (IDLE/START/DATA/PARITY/STOP, 3-bit encoding);
//       the constants LINE_IDLE=1'b1 and LINE_START=1'b0.
//   - Sub-module bit_timer: a CLKS_PER_BIT cycle counter. It restarts on
//     load/state change and gives a one-cycle tick on the last cycle of each
//     bit. The FSM advances only on tick.
// TESTING (bench: WIDTH=4, CLKS_PER_BIT=2, clk period 10)
//   1. Hold rst=1 for 20 ns -> s_out=1, in_ready=1, busy=0, done=0 throughout.
//   2. Accept 4'b1010, parity off -> s_out per cycle is
//      0,0, 1,1, 0,0, 1,1, 0,0, 1,1. done pulses in cycle 12; in_ready=1 in
//      cycle 13.
//   3. Send 4'b1011 with PISO_TX_PARITY_EN -> parity bit is 1 for 2 cycles
//      before STOP; frame length is 14 cycles.
//   4. Pulse in_valid with 4'b1111 while busy, then change p_in -> the frame in
//      progress is unchanged and no extra frame is sent.
//   5. Keep in_valid high with words 4'b0011 then 4'b1100 -> two frames, one
//      IDLE cycle between them, and both bit patterns correct.
//   6. Assert rst in cycle 5 of a frame -> s_out=1 at once, busy=0, no done;
//      the next accepted word sends a clean frame.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and line levels for the framed serial transmitter.
package piso_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/piso_tx_if.sv
// Valid/ready word handshake between the PIPO register stage and piso_tx.
interface piso_tx_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] p_in;

  modport master (output in_valid, output p_in, input  in_ready);
  modport slave  (input  in_valid, input  p_in, output in_ready);
endinterface

// File: rtl/bit_timer.sv
// Per-bit cycle counter: ticks on the last cycle of every serial bit while enabled.
module bit_timer #(
  parameter int CLKS_PER_BIT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || !en || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/piso_tx.sv
// Framed PISO transmitter: start bit, data MSB-first, optional even parity, stop bit.
// Define PISO_TX_PARITY_EN to build the parity bit between DATA and STOP.
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 2
) (
  input  logic       clk,
  input  logic       rst,
  piso_tx_if.slave   in_if,
  output logic       s_out,
  output logic       busy,
  output logic       done
);
  localparam int BIT_W = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             ready;
  logic             accept;
  logic             tick;
`ifdef PISO_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  assign ready          = (state_q == IDLE);
  assign accept         = ready && in_if.in_valid;
  assign in_if.in_ready = ready;
  assign busy           = !ready;

  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .en   (busy),
    .tick (tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    s_out     = LINE_IDLE;
    done      = 1'b0;
`ifdef PISO_TX_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_if.in_valid) begin
          state_d   = START;
          shift_d   = in_if.p_in;
          bit_cnt_d = '0;
`ifdef PISO_TX_PARITY_EN
          par_d     = ^in_if.p_in;
`endif
        end
      end
      START: begin
        s_out = LINE_START;
        if (tick) state_d = DATA;
      end
      DATA: begin
        // The word shifts left so the outgoing bit is always the MSB.
        s_out = shift_q[WIDTH-1];
        if (tick) begin
          shift_d   = shift_q << 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_W'(WIDTH - 1)) begin
            bit_cnt_d = '0;
`ifdef PISO_TX_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end
        end
      end
`ifdef PISO_TX_PARITY_EN
      PARITY: begin
        s_out = par_q;
        if (tick) state_d = STOP;
      end
`endif
      STOP: begin
        s_out = LINE_IDLE;
        if (tick) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
`ifdef PISO_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
`ifdef PISO_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end
endmodule
